// File: rtl/snoop_bcast_ctrl.sv
// snoop_bcast_ctrl
// ----------------
// Runs one coherent snoop at a time across NoPorts cache snoop ports.
// The accepted request is broadcast on AC to every port in its mask. Every
// CR response is then collected and OR-combined into a single CRRESP. The
// data of the lowest-indexed port that reported DataTransfer is forwarded.
// CD beats from any other port that also reported DataTransfer are accepted
// and discarded.
//
// Ports
//   clk_i, rst_ni            clock, synchronous active-low reset
//   req_*                    incoming snoop request (valid/ready, addr, code, port mask)
//   ac_valid_o/ac_ready_i    per-port AC handshake; ac_addr_o/ac_snoop_o shared, registered
//   cr_valid_i/cr_ready_o    per-port CR handshake; cr_resp_i packed 5 bits per port
//   cd_valid_i/cd_ready_o    per-port CD handshake; cd_data_i/cd_last_i packed per port
//   resp_valid_o/resp_ready_i aggregated CRRESP (resp_o) plus data source index (resp_src_o)
//   cd_valid_o/cd_ready_i    forwarded CD stream (cd_data_o, cd_last_o)
//   busy_o                   high whenever a transaction is in flight
module snoop_bcast_ctrl #(
  parameter int NoPorts   = 4,
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AddrWidth-1:0]         req_addr_i,
  input  logic [3:0]                   req_snoop_i,
  input  logic [NoPorts-1:0]           req_mask_i,
  output logic [NoPorts-1:0]           ac_valid_o,
  input  logic [NoPorts-1:0]           ac_ready_i,
  output logic [AddrWidth-1:0]         ac_addr_o,
  output logic [3:0]                   ac_snoop_o,
  input  logic [NoPorts-1:0]           cr_valid_i,
  output logic [NoPorts-1:0]           cr_ready_o,
  input  logic [5*NoPorts-1:0]         cr_resp_i,
  input  logic [NoPorts-1:0]           cd_valid_i,
  output logic [NoPorts-1:0]           cd_ready_o,
  input  logic [DataWidth*NoPorts-1:0] cd_data_i,
  input  logic [NoPorts-1:0]           cd_last_i,
  output logic                         resp_valid_o,
  input  logic                         resp_ready_i,
  output logic [4:0]                   resp_o,
  output logic [$clog2(NoPorts)-1:0]   resp_src_o,
  output logic                         cd_valid_o,
  input  logic                         cd_ready_i,
  output logic [DataWidth-1:0]         cd_data_o,
  output logic                         cd_last_o,
  output logic                         busy_o
);

  localparam int IdxWidth = $clog2(NoPorts);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_RESP,
    ST_DATA
  } state_t;

  state_t                state_reg, state_next;
  logic [AddrWidth-1:0]  addr_reg, addr_next;
  logic [3:0]            snoop_reg, snoop_next;
  logic [NoPorts-1:0]    mask_reg, mask_next;
  logic [NoPorts-1:0]    ac_done_reg, ac_done_next;
  logic [NoPorts-1:0]    cr_done_reg, cr_done_next;
  logic [NoPorts-1:0]    cd_done_reg, cd_done_next;
  logic [NoPorts-1:0]    data_mask_reg, data_mask_next;
  logic [3:0]            agg_reg, agg_next;

  // Per-port views of the packed response and data buses.
  logic [4:0]            cr_resp_arr [NoPorts];
  logic [DataWidth-1:0]  cd_data_arr [NoPorts];

  for (genvar gi = 0; gi < NoPorts; gi++) begin : g_unpack
    assign cr_resp_arr[gi] = cr_resp_i[gi*5 +: 5];
    assign cd_data_arr[gi] = cd_data_i[gi*DataWidth +: DataWidth];
  end

  // Lowest-indexed port that will supply data. This index stays valid
  // through DATA because data_mask_reg only changes in IDLE/COLLECT.
  logic [IdxWidth-1:0] src_sel;
  always_comb begin
    src_sel = '0;
    for (int i = NoPorts - 1; i >= 0; i--) begin
      if (data_mask_reg[i]) src_sel = IdxWidth'(i);
    end
  end

  // Unqualified output values; they are forced low below while in reset.
  logic                req_ready_c;
  logic [NoPorts-1:0]  ac_valid_c, cr_ready_c, cd_ready_c;
  logic                resp_valid_c, cd_valid_c, cd_last_c;
  logic [NoPorts-1:0]  ac_hs, cr_hs, cd_hs, last_hs;

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    snoop_next     = snoop_reg;
    mask_next      = mask_reg;
    ac_done_next   = ac_done_reg;
    cr_done_next   = cr_done_reg;
    cd_done_next   = cd_done_reg;
    data_mask_next = data_mask_reg;
    agg_next       = agg_reg;
    req_ready_c    = 1'b0;
    ac_valid_c     = '0;
    cr_ready_c     = '0;
    cd_ready_c     = '0;
    resp_valid_c   = 1'b0;
    cd_valid_c     = 1'b0;
    cd_last_c      = 1'b0;
    ac_hs          = '0;
    cr_hs          = '0;
    cd_hs          = '0;
    last_hs        = '0;

    case (state_reg)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (req_valid_i) begin
          addr_next      = req_addr_i;
          snoop_next     = req_snoop_i;
          mask_next      = req_mask_i;
          ac_done_next   = '0;
          cr_done_next   = '0;
          cd_done_next   = '0;
          data_mask_next = '0;
          agg_next       = '0;
          // Nothing to snoop: answer immediately with an all-zero response.
          state_next     = (req_mask_i == '0) ? ST_RESP : ST_COLLECT;
        end
      end

      ST_COLLECT: begin
        ac_valid_c = mask_reg & ~ac_done_reg;
        // Registered ac_done keeps CR one cycle behind its AC handshake.
        cr_ready_c = ac_done_reg & ~cr_done_reg;
        ac_hs      = ac_valid_c & ac_ready_i;
        cr_hs      = cr_ready_c & cr_valid_i;
        ac_done_next = ac_done_reg | ac_hs;
        cr_done_next = cr_done_reg | cr_hs;
        for (int i = 0; i < NoPorts; i++) begin
          if (cr_hs[i]) begin
            agg_next          = agg_next | cr_resp_arr[i][4:1];
            data_mask_next[i] = data_mask_reg[i] | cr_resp_arr[i][0];
          end
        end
        if (cr_done_next == mask_reg) state_next = ST_RESP;
      end

      ST_RESP: begin
        resp_valid_c = 1'b1;
        if (resp_ready_i) begin
          state_next = (data_mask_reg != '0) ? ST_DATA : ST_IDLE;
        end
      end

      ST_DATA: begin
        // The selected port stops forwarding once its last beat is taken.
        // The other data ports may still be draining at that point.
        cd_valid_c = cd_valid_i[src_sel] & ~cd_done_reg[src_sel];
        cd_last_c  = cd_last_i[src_sel] & ~cd_done_reg[src_sel];
        for (int i = 0; i < NoPorts; i++) begin
          if (i == int'(src_sel)) begin
            cd_ready_c[i] = cd_ready_i & ~cd_done_reg[i];
          end else begin
            cd_ready_c[i] = data_mask_reg[i] & ~cd_done_reg[i];
          end
        end
        cd_hs        = cd_ready_c & cd_valid_i;
        last_hs      = cd_hs & cd_last_i;
        cd_done_next = cd_done_reg | last_hs;
        if (cd_done_next == data_mask_reg) state_next = ST_IDLE;
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      snoop_reg     <= '0;
      mask_reg      <= '0;
      ac_done_reg   <= '0;
      cr_done_reg   <= '0;
      cd_done_reg   <= '0;
      data_mask_reg <= '0;
      agg_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      snoop_reg     <= snoop_next;
      mask_reg      <= mask_next;
      ac_done_reg   <= ac_done_next;
      cr_done_reg   <= cr_done_next;
      cd_done_reg   <= cd_done_next;
      data_mask_reg <= data_mask_next;
      agg_reg       <= agg_next;
    end
  end

  // Handshake outputs are held low for the whole time reset is asserted,
  // not only from the first reset edge onward.
  assign req_ready_o  = rst_ni & req_ready_c;
  assign ac_valid_o   = {NoPorts{rst_ni}} & ac_valid_c;
  assign cr_ready_o   = {NoPorts{rst_ni}} & cr_ready_c;
  assign cd_ready_o   = {NoPorts{rst_ni}} & cd_ready_c;
  assign resp_valid_o = rst_ni & resp_valid_c;
  assign cd_valid_o   = rst_ni & cd_valid_c;
  assign cd_last_o    = rst_ni & cd_last_c;
  assign busy_o       = rst_ni & (state_reg != ST_IDLE);

  assign ac_addr_o    = addr_reg;
  assign ac_snoop_o   = snoop_reg;
  assign resp_o       = {agg_reg, |data_mask_reg};
  assign resp_src_o   = src_sel;
  assign cd_data_o    = cd_data_arr[src_sel];

endmodule

// File: tb/tb_snoop_bcast_ctrl.sv
// Testbench for snoop_bcast_ctrl (NoPorts=4, 64-bit address/data).
// One table record is one clock cycle. It holds the inputs driven during
// that cycle and the outputs expected before the next rising edge. A short
// hand-written sequence at the end covers the minimum latency path, the
// shared AC fields, and a drain port that outlives the forwarded port.
module tb_snoop_bcast_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [63:0]  req_addr_i;
  logic [3:0]   req_snoop_i;
  logic [3:0]   req_mask_i;
  logic [3:0]   ac_valid_o;
  logic [3:0]   ac_ready_i;
  logic [63:0]  ac_addr_o;
  logic [3:0]   ac_snoop_o;
  logic [3:0]   cr_valid_i;
  logic [3:0]   cr_ready_o;
  logic [19:0]  cr_resp_i;
  logic [3:0]   cd_valid_i;
  logic [3:0]   cd_ready_o;
  logic [255:0] cd_data_i;
  logic [3:0]   cd_last_i;
  logic         resp_valid_o;
  logic         resp_ready_i;
  logic [4:0]   resp_o;
  logic [1:0]   resp_src_o;
  logic         cd_valid_o;
  logic         cd_ready_i;
  logic [63:0]  cd_data_o;
  logic         cd_last_o;
  logic         busy_o;

  always #5 clk_i = ~clk_i;

  snoop_bcast_ctrl #(.NoPorts(4), .AddrWidth(64), .DataWidth(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .req_snoop_i(req_snoop_i), .req_mask_i(req_mask_i),
    .ac_valid_o(ac_valid_o), .ac_ready_i(ac_ready_i), .ac_addr_o(ac_addr_o),
    .ac_snoop_o(ac_snoop_o),
    .cr_valid_i(cr_valid_i), .cr_ready_o(cr_ready_o), .cr_resp_i(cr_resp_i),
    .cd_valid_i(cd_valid_i), .cd_ready_o(cd_ready_o), .cd_data_i(cd_data_i),
    .cd_last_i(cd_last_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
    .resp_src_o(resp_src_o),
    .cd_valid_o(cd_valid_o), .cd_ready_i(cd_ready_i), .cd_data_o(cd_data_o),
    .cd_last_o(cd_last_o), .busy_o(busy_o)
  );

  typedef struct {
    logic        rst;
    logic        rv;
    logic [3:0]  m;
    logic [3:0]  acr;
    logic [3:0]  crv;
    logic [19:0] crr;
    logic        rr;
    logic [3:0]  cdv;
    logic [3:0]  cdl;
    logic [31:0] cdd;   // one byte of beat data per port
    logic        cdr;
    logic        e_rq;
    logic [3:0]  e_ac;
    logic [3:0]  e_cr;
    logic        e_rv;
    logic [4:0]  e_resp;
    logic [1:0]  e_src;
    logic        e_cdv;
    logic        e_cdl;
    logic [7:0]  e_cdd;
    logic [3:0]  e_cdr;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic v(input logic rst, input logic rv, input logic [3:0] m, input logic [3:0] acr,
                   input logic [3:0] crv, input logic [19:0] crr, input logic rr,
                   input logic [3:0] cdv, input logic [3:0] cdl, input logic [31:0] cdd,
                   input logic cdr,
                   input logic e_rq, input logic [3:0] e_ac, input logic [3:0] e_cr,
                   input logic e_rv, input logic [4:0] e_resp, input logic [1:0] e_src,
                   input logic e_cdv, input logic e_cdl, input logic [7:0] e_cdd,
                   input logic [3:0] e_cdr, input logic e_busy);
    vec_t t;
    t.rst = rst; t.rv = rv; t.m = m; t.acr = acr; t.crv = crv; t.crr = crr; t.rr = rr;
    t.cdv = cdv; t.cdl = cdl; t.cdd = cdd; t.cdr = cdr;
    t.e_rq = e_rq; t.e_ac = e_ac; t.e_cr = e_cr; t.e_rv = e_rv; t.e_resp = e_resp;
    t.e_src = e_src; t.e_cdv = e_cdv; t.e_cdl = e_cdl; t.e_cdd = e_cdd; t.e_cdr = e_cdr;
    t.e_busy = e_busy;
    vecs.push_back(t);
  endtask

  task automatic set_cd_data(input logic [31:0] bytes);
    for (int p = 0; p < 4; p++) cd_data_i[p*64 +: 64] = {56'h0, bytes[p*8 +: 8]};
  endtask

  task automatic idle_inputs();
    req_valid_i = 0; req_mask_i = 0; ac_ready_i = 0; cr_valid_i = 0; cr_resp_i = 0;
    resp_ready_i = 0; cd_valid_i = 0; cd_last_i = 0; cd_ready_i = 0; set_cd_data(32'h0);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //  rst rv mask    acr      crv      crr                                  rr cdv      cdl      cdd           cdr | rq ac       cr       rv resp      src  cdv cdl cdd    cdr      busy
    // reset held with a pending request, then release
    v(0, 1, 4'b1110, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);
    v(0, 1, 4'b1110, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);
    // empty mask: response one cycle after accept
    v(1, 1, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               1, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);
    // all-miss broadcast to ports 1..3 with AC stalls and staggered IsShared CRs
    v(1, 1, 4'b1110, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b1110, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0010, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b1110, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0100, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b1100, 4'b0010, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b1000, 4'b0010, {10'b0, 5'b01000, 5'b0},             0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b1000, 4'b0110, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0100, {5'b0, 5'b01000, 10'b0},             0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b1100, 0, 5'b01000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b1000, 0, 5'b01000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b1000, {5'b01000, 15'b0},                   0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b1000, 0, 5'b01000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b01000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               1, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b01000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    // multi-data: port1 forwards 0xA,0xB while port2 is drained
    v(1, 1, 4'b0110, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b01000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);
    v(1, 0, 4'b0000, 4'b0110, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0110, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0110, {5'b0, 5'b10001, 5'b00101, 5'b0},    0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0110, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               1, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b10101, 2'd1, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0110, 4'b0000, 32'h00550A00, 1,  0, 4'b0000, 4'b0000, 0, 5'b10101, 2'd1, 1, 0, 8'h0A, 4'b0110, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0110, 4'b0110, 32'h00660B00, 1,  0, 4'b0000, 4'b0000, 0, 5'b10101, 2'd1, 1, 1, 8'h0B, 4'b0110, 1);
    // backpressure on resp_ready_i and cd_ready_i
    v(1, 1, 4'b0011, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b10101, 2'd1, 0, 0, 8'h00, 4'b0000, 0);
    v(1, 0, 4'b0000, 4'b0011, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0011, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0001, {15'b0, 5'b01000},                   0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0011, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0010, {10'b0, 5'b00001, 5'b0},             0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0010, 0, 5'b01000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b01001, 2'd1, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b01001, 2'd1, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               1, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b01001, 2'd1, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0010, 4'b0010, 32'h0000C300, 0,  0, 4'b0000, 4'b0000, 0, 5'b01001, 2'd1, 1, 1, 8'hC3, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0010, 4'b0010, 32'h0000C300, 0,  0, 4'b0000, 4'b0000, 0, 5'b01001, 2'd1, 1, 1, 8'hC3, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0010, 4'b0010, 32'h0000C300, 0,  0, 4'b0000, 4'b0000, 0, 5'b01001, 2'd1, 1, 1, 8'hC3, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0010, 4'b0010, 32'h0000C300, 1,  0, 4'b0000, 4'b0000, 0, 5'b01001, 2'd1, 1, 1, 8'hC3, 4'b0010, 1);
    // reset in DATA after the first forwarded beat, then a clean transaction
    v(1, 1, 4'b0100, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b01001, 2'd1, 0, 0, 8'h00, 4'b0000, 0);
    v(1, 0, 4'b0000, 4'b0100, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0100, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0100, {5'b0, 5'b00001, 10'b0},             0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0100, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               1, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b00001, 2'd2, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0100, 4'b0000, 32'h00110000, 1,  0, 4'b0000, 4'b0000, 0, 5'b00001, 2'd2, 1, 0, 8'h11, 4'b0100, 1);
    v(0, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0100, 4'b0100, 32'h00220000, 1,  0, 4'b0000, 4'b0000, 0, 5'b00001, 2'd2, 0, 0, 8'h22, 4'b0000, 0);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);
    v(1, 1, 4'b0001, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);
    v(1, 0, 4'b0000, 4'b0001, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0001, 4'b0000, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0001, {15'b0, 5'b01000},                   0, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0001, 0, 5'b00000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               1, 4'b0000, 4'b0000, 32'h0,        0,  0, 4'b0000, 4'b0000, 1, 5'b01000, 2'd0, 0, 0, 8'h00, 4'b0000, 1);
    v(1, 0, 4'b0000, 4'b0000, 4'b0000, 20'h0,                               0, 4'b0000, 4'b0000, 32'h0,        0,  1, 4'b0000, 4'b0000, 0, 5'b01000, 2'd0, 0, 0, 8'h00, 4'b0000, 0);

    // Prologue: one reset edge so every register starts from a known value.
    req_addr_i  = 64'hDEAD_BEEF_0000_1000;
    req_snoop_i = 4'h1;
    cd_data_i   = '0;
    idle_inputs();
    rst_ni = 1'b0;
    next_cycle();

    for (int k = 0; k < vecs.size(); k++) begin
      rst_ni       = vecs[k].rst;
      req_valid_i  = vecs[k].rv;
      req_mask_i   = vecs[k].m;
      ac_ready_i   = vecs[k].acr;
      cr_valid_i   = vecs[k].crv;
      cr_resp_i    = vecs[k].crr;
      resp_ready_i = vecs[k].rr;
      cd_valid_i   = vecs[k].cdv;
      cd_last_i    = vecs[k].cdl;
      set_cd_data(vecs[k].cdd);
      cd_ready_i   = vecs[k].cdr;
      #3;
      chk($sformatf("v%0d req_ready", k),  64'(req_ready_o),  64'(vecs[k].e_rq));
      chk($sformatf("v%0d ac_valid", k),   64'(ac_valid_o),   64'(vecs[k].e_ac));
      chk($sformatf("v%0d cr_ready", k),   64'(cr_ready_o),   64'(vecs[k].e_cr));
      chk($sformatf("v%0d resp_valid", k), 64'(resp_valid_o), 64'(vecs[k].e_rv));
      chk($sformatf("v%0d resp", k),       64'(resp_o),       64'(vecs[k].e_resp));
      chk($sformatf("v%0d resp_src", k),   64'(resp_src_o),   64'(vecs[k].e_src));
      chk($sformatf("v%0d cd_valid", k),   64'(cd_valid_o),   64'(vecs[k].e_cdv));
      chk($sformatf("v%0d cd_last", k),    64'(cd_last_o),    64'(vecs[k].e_cdl));
      chk($sformatf("v%0d cd_data", k),    cd_data_o,         64'(vecs[k].e_cdd));
      chk($sformatf("v%0d cd_ready", k),   64'(cd_ready_o),   64'(vecs[k].e_cdr));
      chk($sformatf("v%0d busy", k),       64'(busy_o),       64'(vecs[k].e_busy));
      next_cycle();
    end

    // Minimum latency path with registered AC fields. Port0 forwards a
    // single beat while port1 keeps draining for one more cycle.
    idle_inputs();
    rst_ni      = 1'b1;
    req_addr_i  = 64'h1234_5678_9ABC_DEF0;
    req_snoop_i = 4'h7;
    req_mask_i  = 4'b0011;
    req_valid_i = 1'b1;
    #3;
    chk("lat0 req_ready", 64'(req_ready_o), 64'd1);
    next_cycle();
    req_valid_i = 1'b0;
    req_addr_i  = 64'h0;
    req_snoop_i = 4'h0;
    ac_ready_i  = 4'b0011;
    #3;
    chk("lat1 ac_valid", 64'(ac_valid_o), 64'b0011);
    chk("lat1 ac_addr",  ac_addr_o, 64'h1234_5678_9ABC_DEF0);
    chk("lat1 ac_snoop", 64'(ac_snoop_o), 64'h7);
    chk("lat1 cr_ready", 64'(cr_ready_o), 64'b0000);
    next_cycle();
    ac_ready_i = 4'b0000;
    cr_valid_i = 4'b0011;
    cr_resp_i  = {10'b0, 5'b00001, 5'b00001};
    #3;
    chk("lat2 cr_ready", 64'(cr_ready_o), 64'b0011);
    chk("lat2 ac_valid", 64'(ac_valid_o), 64'b0000);
    next_cycle();
    cr_valid_i   = 4'b0000;
    resp_ready_i = 1'b1;
    #3;
    chk("lat3 resp_valid", 64'(resp_valid_o), 64'd1);
    chk("lat3 resp",       64'(resp_o), 64'b00001);
    chk("lat3 resp_src",   64'(resp_src_o), 64'd0);
    next_cycle();
    resp_ready_i = 1'b0;
    cd_valid_i   = 4'b0011;
    cd_last_i    = 4'b0001;
    set_cd_data(32'h0000_7799);
    cd_ready_i   = 1'b1;
    #3;
    chk("drain0 cd_valid", 64'(cd_valid_o), 64'd1);
    chk("drain0 cd_last",  64'(cd_last_o), 64'd1);
    chk("drain0 cd_data",  cd_data_o, 64'h99);
    chk("drain0 cd_ready", 64'(cd_ready_o), 64'b0011);
    next_cycle();
    cd_last_i = 4'b0011;
    #3;
    chk("drain1 cd_valid", 64'(cd_valid_o), 64'd0);
    chk("drain1 cd_ready", 64'(cd_ready_o), 64'b0010);
    chk("drain1 busy",     64'(busy_o), 64'd1);
    next_cycle();
    idle_inputs();
    #3;
    chk("drain2 busy",      64'(busy_o), 64'd0);
    chk("drain2 req_ready", 64'(req_ready_o), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
